pipelined_cla_addsub: RTL and testbench

- Parametrised N-bit carry-lookahead adder/subtractor, pipelined by segment. N bits are split into SEG-bit lookahead segments; one segment is resolved per pipeline stage, and the carry is registered between stages.
- Adds a subtract mode, signed overflow/zero flags and a valid/ready stream handshake.
- Sits in the arithmetic datapath as the high-width, high-Fmax replacement for the single-cycle lookahead adder.

---
 rtl/arith_pkg.sv | 32 +++
 rtl/cla_segment.sv | 49 ++++
 rtl/pipelined_cla_addsub.sv | 133 +++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the pipelined lookahead adder/subtractor.
//   OP_ADD / OP_SUB : values of the per-beat 'sub' mode bit.
//   stage_t         : bundle carried between lookahead pipeline stages.
//   calc_nseg       : number of pipeline stages for an N-bit, SEG-bit split.
//   seg_cfg_ok      : legality test for an (N, SEG) pair.
package arith_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest operand the stage bundle can carry. Narrower datapaths
    // zero-extend into it; the unused upper bits are constant and get pruned.
    localparam int MAX_N = 128;

    typedef struct packed {
        logic             vld;    // beat occupies this stage
        logic [MAX_N-1:0] a;      // operand A, segments not yet resolved
        logic [MAX_N-1:0] b;      // operand B as presented (inverted per segment when sub)
        logic             carry;  // carry into the next unresolved segment
        logic             sub;    // mode of this beat
        logic [MAX_N-1:0] sum;    // low segments already resolved (deskew)
    } stage_t;

    function automatic int calc_nseg(input int n, input int seg);
        return n / seg;
    endfunction

    function automatic bit seg_cfg_ok(input int n, input int seg);
        return (seg > 0) && (n > 0) && (n <= MAX_N) && ((n % seg) == 0);
    endfunction

endpackage

// File: rtl/cla_segment.sv
// One SEG-bit carry-lookahead segment, purely combinational.
//   a, b   : segment operand bits (b already inverted for subtraction)
//   cin    : carry into the segment
//   sum    : segment sum bits
//   cout   : carry out of the segment MSB
//   c_msb  : carry into the segment MSB (used for signed overflow)
module cla_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);

    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is built as its own sum of products over the generate and
    // propagate terms below it plus cin, so no carry depends on another.
    always_comb begin
        logic acc;
        logic prop;
        c    = '0;
        acc  = 1'b0;
        prop = 1'b0;
        c[0] = cin;
        for (int i = 0; i < SEG; i++) begin
            acc  = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = acc | (prop & cin);
        end
    end

    assign sum   = p ^ c[SEG-1:0];
    assign cout  = c[SEG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// N-bit adder/subtractor resolved one SEG-bit lookahead segment per stage.
// Stage k resolves segment k; operands for the upper segments ride along in
// a skew register and resolved low sum bits in a deskew register, so the
// whole result appears at once NSEG cycles after acceptance.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand beat handshake
//   a, b, c_in, sub     : operands, carry/borrow-in, mode (0 add, 1 subtract)
//   out_valid/out_ready : result handshake
//   sum, c_out          : result and carry-out (NOT borrow-out when subtracting)
//   ovf, zero           : signed overflow, result equals zero
module pipelined_cla_addsub
    import arith_pkg::*;
#(
    parameter int N   = 32,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         ovf,
    output logic         zero
);

    localparam int NSEG = calc_nseg(N, SEG);

    if (!seg_cfg_ok(N, SEG)) begin : g_cfg_err
        $error("pipelined_cla_addsub: N must be a positive multiple of SEG and at most MAX_N");
    end

    // Single global enable: the whole pipe advances or the whole pipe holds.
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        stage_t         cur;
        logic [SEG-1:0] seg_b;
        logic [SEG-1:0] seg_sum;
        logic           seg_cout;
        logic           seg_cmsb;

        if (k == 0) begin : g_in
            // Stage 0 input: raw port values; a borrow-in becomes an inverted carry-in.
            always_comb begin
                cur       = '0;
                cur.vld   = in_valid;
                cur.a     = MAX_N'(a);
                cur.b     = MAX_N'(b);
                cur.sub   = sub;
                cur.carry = c_in ^ sub;
            end
        end else begin : g_mid
            assign cur = g_seg[k-1].g_reg.stg_p;
        end

        assign seg_b = cur.b[k*SEG +: SEG] ^ {SEG{cur.sub == OP_SUB}};

        cla_segment #(
            .SEG (SEG)
        ) u_cla (
            .a     (cur.a[k*SEG +: SEG]),
            .b     (seg_b),
            .cin   (cur.carry),
            .sum   (seg_sum),
            .cout  (seg_cout),
            .c_msb (seg_cmsb)
        );

        if (k < NSEG - 1) begin : g_reg
            stage_t nxt;
            stage_t stg_p;

            always_comb begin
                nxt                   = cur;
                nxt.sum[k*SEG +: SEG] = seg_sum;
                nxt.carry             = seg_cout;
            end

            // ---- stage k -> stage k+1 boundary ----
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stg_p.vld <= 1'b0;
                end else if (adv) begin
                    stg_p <= nxt;
                end
            end
        end
    end

    // Final segment: merge its bits with the deskewed low segments.
    logic         last_vld;
    logic [N-1:0] last_sum;
    logic         last_cout;
    logic         last_cmsb;

    assign last_vld  = g_seg[NSEG-1].cur.vld;
    assign last_cout = g_seg[NSEG-1].seg_cout;
    assign last_cmsb = g_seg[NSEG-1].seg_cmsb;

    always_comb begin
        last_sum               = g_seg[NSEG-1].cur.sum[N-1:0];
        last_sum[N-1 -: SEG]   = g_seg[NSEG-1].seg_sum;
    end

    // ---- final stage -> output register boundary ----
    // Signed overflow is the disagreement between the carries into and out of
    // the MSB, equivalent to same-sign operands producing an opposite-sign sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (adv) begin
            out_valid <= last_vld;
            sum       <= last_sum;
            c_out     <= last_cout;
            ovf       <= last_cout ^ last_cmsb;
            zero      <= ~|last_sum;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub at N=16 with SEG=4, 16 and 2.
// Each lane runs its own DUT, driver and monitor on a shared clock.
module tb_pipelined_cla_addsub;

    localparam int N = 16;

    typedef struct packed {
        logic        sub;
        logic        cin;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
        bit          lat;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    task automatic check(input string nm, input int lane, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s lane%0d: got %h expected %h", nm, lane, act, exp_v);
        end
    endtask

    // Hand-computed vectors: sub, c_in, a, b, sum, c_out, ovf.
    function automatic vec_t get_vec(input int i);
        vec_t v;
        case (i)
            0:  v = '{1'b0, 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0};
            1:  v = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0};
            2:  v = '{1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
            3:  v = '{1'b1, 1'b0, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0};
            4:  v = '{1'b0, 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
            5:  v = '{1'b1, 1'b0, 16'h5000, 16'h1000, 16'h4000, 1'b1, 1'b0};
            6:  v = '{1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
            7:  v = '{1'b1, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0};
            8:  v = '{1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
            9:  v = '{1'b1, 1'b0, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1};
            10: v = '{1'b0, 1'b1, 16'h0F0F, 16'hF0F0, 16'h0000, 1'b1, 1'b0};
            11: v = '{1'b1, 1'b0, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
            12: v = '{1'b0, 1'b0, 16'hABCD, 16'h1111, 16'hBCDE, 1'b0, 1'b0};
            13: v = '{1'b1, 1'b1, 16'h0010, 16'h0001, 16'h000E, 1'b1, 1'b0};
            14: v = '{1'b0, 1'b0, 16'h4000, 16'h4000, 16'h8000, 1'b0, 1'b1};
            15: v = '{1'b1, 1'b1, 16'h8000, 16'h0000, 16'h7FFF, 1'b1, 1'b1};
            16: v = '{1'b0, 1'b1, 16'h0001, 16'h0002, 16'h0004, 1'b0, 1'b0};
            17: v = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
            18: v = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 1'b0};
            19: v = '{1'b1, 1'b0, 16'h8000, 16'h7FFF, 16'h0001, 1'b1, 1'b1};
            20: v = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0};
            21: v = '{1'b1, 1'b0, 16'h1000, 16'h2000, 16'hF000, 1'b0, 1'b0};
            22: v = '{1'b0, 1'b0, 16'h1FFF, 16'h0001, 16'h2000, 1'b0, 1'b0};
            default: v = '{1'b1, 1'b0, 16'h0100, 16'h00FF, 16'h0001, 1'b1, 1'b0};
        endcase
        return v;
    endfunction

    for (genvar L = 0; L < 3; L++) begin : g_lane
        localparam int LSEG = (L == 0) ? 4 : ((L == 1) ? 16 : 2);
        localparam int LAT  = N / LSEG;

        logic         rst_n;
        logic         in_valid;
        logic         in_ready;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         c_in;
        logic         sub;
        logic         out_valid;
        logic         out_ready;
        logic [N-1:0] sum;
        logic         c_out;
        logic         ovf;
        logic         zero;
        exp_t         q[$];

        pipelined_cla_addsub #(
            .N   (N),
            .SEG (LSEG)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .c_in      (c_in),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .c_out     (c_out),
            .ovf       (ovf),
            .zero      (zero)
        );

        // Issue vectors lo..hi back to back; optionally hold out_ready low for
        // cycles 8..10 of the run. Expected results go to the scoreboard on accept.
        task automatic run_vecs(input int lo, input int hi, input bit stall, input bit lat);
            int   i;
            int   t;
            bit   acc;
            vec_t v;
            exp_t e;
            i = lo;
            t = 0;
            while (i <= hi && t < 200) begin
                @(negedge clk);
                out_ready = !(stall && t >= 8 && t < 11);
                v         = get_vec(i);
                in_valid  = 1'b1;
                a         = v.a;
                b         = v.b;
                sub       = v.sub;
                c_in      = v.cin;
                #1;
                if (out_valid && !out_ready)
                    check("in_ready_stall", L, 32'(in_ready), 32'd0);
                acc   = in_ready;
                e.s   = v.s;
                e.co  = v.co;
                e.ov  = v.ov;
                e.z   = (v.s == 16'h0000);
                e.lat = lat;
                e.cyc = cyc;
                @(posedge clk);
                if (acc) begin
                    q.push_back(e);
                    i++;
                end
                t++;
            end
            if (i <= hi)
                check("issue_timeout", L, 32'(i), 32'(hi + 1));
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
        endtask

        task automatic wait_drain();
            int k;
            k = 0;
            while (q.size() != 0 && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("drain_empty", L, 32'(q.size()), 32'd0);
        endtask

        initial begin
            rst_n     = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            a         = '0;
            b         = '0;
            c_in      = 1'b0;
            sub       = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            check("rst_out_valid", L, 32'(out_valid), 32'd0);
            check("rst_sum", L, 32'(sum), 32'd0);
            check("rst_flags", L, 32'({c_out, ovf, zero}), 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            check("rst_in_ready", L, 32'(in_ready), 32'd1);

            run_vecs(0, 3, 1'b0, 1'b1);
            repeat (LAT + 2) @(negedge clk);
            run_vecs(4, 23, 1'b1, 1'b0);
            wait_drain();

            // Fill the pipe while the output is blocked, then reset it.
            @(negedge clk);
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a         = 16'h1234;
            b         = 16'h1111;
            sub       = 1'b0;
            c_in      = 1'b0;
            repeat (LAT + 2) @(negedge clk);
            #1;
            check("full_before_rst", L, 32'(out_valid), 32'd1);
            in_valid = 1'b0;
            rst_n    = 1'b0;
            #1;
            check("async_rst_out_valid", L, 32'(out_valid), 32'd0);
            check("async_rst_in_ready", L, 32'(in_ready), 32'd1);
            @(negedge clk);
            rst_n     = 1'b1;
            out_ready = 1'b1;
            run_vecs(0, 0, 1'b0, 1'b1);
            repeat (LAT + 4) @(negedge clk);
            wait_drain();
            n_done++;
        end

        initial begin
            bit          hold;
            logic [18:0] prev;
            exp_t        e;
            hold = 1'b0;
            prev = '0;
            forever begin
                @(negedge clk);
                #2;
                if (!rst_n) begin
                    hold = 1'b0;
                end else begin
                    if (out_valid && !out_ready) begin
                        if (hold)
                            check("stall_stable", L, 32'({sum, c_out, ovf, zero}), 32'(prev));
                        hold = 1'b1;
                        prev = {sum, c_out, ovf, zero};
                    end else begin
                        hold = 1'b0;
                    end
                    if (out_valid && out_ready) begin
                        if (q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_beat lane%0d: sum %h emerged with empty scoreboard", L, sum);
                        end else begin
                            e = q.pop_front();
                            check("sum", L, 32'(sum), 32'(e.s));
                            check("cout_ovf_zero", L, 32'({c_out, ovf, zero}), 32'({e.co, e.ov, e.z}));
                            if (e.lat)
                                check("latency", L, 32'(cyc - e.cyc), 32'(LAT));
                        end
                    end
                end
            end
        end
    end

    initial begin
        int k;
        k = 0;
        while (n_done < 3 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (n_done < 3) begin
            n_checks++;
            n_fail++;
            $display("FAIL lanes_done: %0d of 3 lanes finished", n_done);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
